// File: rtl/branch_target_buffer.sv
// Fully-associative branch target buffer with 2-bit direction counters,
// zero-latency lookup, resolution-side allocation and usage statistics.
module branch_target_buffer #(
  parameter int ENTRIES = 8,
  parameter int PC_W    = 32
) (
  input  logic            clk,
  input  logic            clear_n,
  input  logic            query,
  input  logic [PC_W-1:0] pc_query,
  output logic            success,
  output logic [PC_W-1:0] predict,
  input  logic            store,
  input  logic            pred_result,
  input  logic [PC_W-1:0] pc_update,
  input  logic [PC_W-1:0] next_pc,
  input  logic            invalidate,
  output logic [31:0]     query_cnt,
  output logic [31:0]     hit_cnt,
  output logic [31:0]     correct_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);

  // query and store are single-cycle strobes with no back-pressure: the
  // lookup answers in the same cycle and an update is always accepted.

  logic [ENTRIES-1:0] r_valid;
  logic [PC_W-1:0]    r_tag    [ENTRIES];
  logic [PC_W-1:0]    r_target [ENTRIES];
  logic [1:0]         r_ctr    [ENTRIES];
  logic [IDX_W-1:0]   r_ptr;
  logic [31:0]        r_query_cnt;
  logic [31:0]        r_hit_cnt;
  logic [31:0]        r_correct_cnt;

  logic               w_q_match;
  logic [IDX_W-1:0]   w_q_idx;
  logic               w_u_match;
  logic [IDX_W-1:0]   w_u_idx;
  logic               w_free;
  logic [IDX_W-1:0]   w_free_idx;
  logic [IDX_W-1:0]   w_alloc_idx;
  logic               w_taken;
  logic               w_success;

  // Searches run from the top index down so the lowest index wins.
  always_comb begin
    w_q_match  = 1'b0;
    w_q_idx    = '0;
    w_u_match  = 1'b0;
    w_u_idx    = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_tag[i] == pc_query)) begin
        w_q_match = 1'b1;
        w_q_idx   = IDX_W'(i);
      end
      if (r_valid[i] && (r_tag[i] == pc_update)) begin
        w_u_match = 1'b1;
        w_u_idx   = IDX_W'(i);
      end
      if (!r_valid[i]) begin
        w_free     = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  assign w_success   = query & w_q_match;
  assign w_taken     = (next_pc != (pc_update + PC_W'(4)));
  assign w_alloc_idx = w_free ? w_free_idx : r_ptr;

  always_comb begin
    predict = pc_query + PC_W'(4);
    if (w_success && r_ctr[w_q_idx][1]) begin
      predict = r_target[w_q_idx];
    end
  end

  assign success = w_success;

  // Flush wins over a concurrent resolution update.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_valid <= '0;
      r_ptr   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b00;
      end
    end else if (invalidate) begin
      r_valid <= '0;
      r_ptr   <= '0;
    end else if (store) begin
      if (w_u_match) begin
        if (w_taken) begin
          r_target[w_u_idx] <= next_pc;
          if (r_ctr[w_u_idx] != 2'b11) begin
            r_ctr[w_u_idx] <= r_ctr[w_u_idx] + 2'd1;
          end
        end else if (r_ctr[w_u_idx] != 2'b00) begin
          r_ctr[w_u_idx] <= r_ctr[w_u_idx] - 2'd1;
        end
      end else if (w_taken) begin
        r_valid[w_alloc_idx]  <= 1'b1;
        r_tag[w_alloc_idx]    <= pc_update;
        r_target[w_alloc_idx] <= next_pc;
        r_ctr[w_alloc_idx]    <= 2'b10;
        if (!w_free) begin
          r_ptr <= r_ptr + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_query_cnt   <= '0;
      r_hit_cnt     <= '0;
      r_correct_cnt <= '0;
    end else begin
      r_query_cnt   <= r_query_cnt + 32'(query);
      r_hit_cnt     <= r_hit_cnt + 32'(w_success);
      r_correct_cnt <= r_correct_cnt + 32'(store & pred_result);
    end
  end

  assign query_cnt   = r_query_cnt;
  assign hit_cnt     = r_hit_cnt;
  assign correct_cnt = r_correct_cnt;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer (ENTRIES=8, PC_W=32).
module tb_branch_target_buffer;

  logic        clk;
  logic        clear_n;
  logic        query;
  logic [31:0] pc_query;
  logic        success;
  logic [31:0] predict;
  logic        store;
  logic        pred_result;
  logic [31:0] pc_update;
  logic [31:0] next_pc;
  logic        invalidate;
  logic [31:0] query_cnt;
  logic [31:0] hit_cnt;
  logic [31:0] correct_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q = 0;
  int exp_h = 0;
  int exp_c = 0;

  branch_target_buffer #(.ENTRIES(8), .PC_W(32)) dut (
    .clk(clk), .clear_n(clear_n), .query(query), .pc_query(pc_query),
    .success(success), .predict(predict), .store(store),
    .pred_result(pred_result), .pc_update(pc_update), .next_pc(next_pc),
    .invalidate(invalidate), .query_cnt(query_cnt), .hit_cnt(hit_cnt),
    .correct_cnt(correct_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    query = 1'b0; pc_query = '0; store = 1'b0; pred_result = 1'b0;
    pc_update = '0; next_pc = '0; invalidate = 1'b0;
  endtask

  // One cycle of stimulus; lookup outputs are checked before the edge.
  task automatic cyc(input logic q, input logic [31:0] pq, input logic st,
                     input logic pr, input logic [31:0] pu, input logic [31:0] np,
                     input logic inv, input logic exp_s, input logic [31:0] exp_p,
                     input string tag);
    query = q; pc_query = pq; store = st; pred_result = pr;
    pc_update = pu; next_pc = np; invalidate = inv;
    #2;
    if (q) begin
      chk({tag, "_success"}, {31'b0, success}, {31'b0, exp_s});
      chk({tag, "_predict"}, predict, exp_p);
      exp_q++;
      if (exp_s) exp_h++;
    end
    if (st && pr) exp_c++;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic qry(input logic [31:0] pq, input logic exp_s, input logic [31:0] exp_p,
                     input string tag);
    cyc(1'b1, pq, 1'b0, 1'b0, '0, '0, 1'b0, exp_s, exp_p, tag);
  endtask

  task automatic sto(input logic [31:0] pu, input logic [31:0] np, input logic pr);
    cyc(1'b0, '0, 1'b1, pr, pu, np, 1'b0, 1'b0, '0, "sto");
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, "_query_cnt"}, query_cnt, 32'(exp_q));
    chk({tag, "_hit_cnt"}, hit_cnt, 32'(exp_h));
    chk({tag, "_correct_cnt"}, correct_cnt, 32'(exp_c));
  endtask

  task automatic do_reset();
    clear_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 clear_n = 1'b1;
    exp_q = 0; exp_h = 0; exp_c = 0;
  endtask

  initial begin
    idle_inputs();
    clear_n = 1'b0;
    // 1: lookup while in reset, then idle after release
    #3;
    query = 1'b1; pc_query = 32'h40;
    #1;
    chk("rst_success", {31'b0, success}, 32'd0);
    chk("rst_predict", predict, 32'h44);
    idle_inputs();
    @(posedge clk); #1 clear_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_cnts("idle");

    // 2: allocation with read-before-write on the same cycle
    cyc(1'b1, 32'h40, 1'b1, 1'b0, 32'h40, 32'h80, 1'b0, 1'b0, 32'h44, "same_cyc");
    qry(32'h40, 1'b1, 32'h80, "alloc");

    // 3: counter walk 10 -> 01 -> 00 -> 01 -> 10 -> 11 (saturated)
    sto(32'h40, 32'h44, 1'b0);
    qry(32'h40, 1'b1, 32'h44, "ctr01");
    sto(32'h40, 32'h44, 1'b0);
    qry(32'h40, 1'b1, 32'h44, "ctr00");
    sto(32'h40, 32'h80, 1'b1);
    qry(32'h40, 1'b1, 32'h44, "ctr01_up");
    sto(32'h40, 32'h80, 1'b1);
    qry(32'h40, 1'b1, 32'h80, "ctr10_up");
    repeat (3) sto(32'h40, 32'h80, 1'b1);
    qry(32'h40, 1'b1, 32'h80, "ctr_sat3");
    repeat (2) sto(32'h40, 32'h80, 1'b1);
    sto(32'h40, 32'h44, 1'b0);
    qry(32'h40, 1'b1, 32'h80, "sat_dec1");
    sto(32'h40, 32'h44, 1'b0);
    qry(32'h40, 1'b1, 32'h44, "sat_dec2");
    sto(32'h40, 32'h90, 1'b0);
    sto(32'h40, 32'h90, 1'b0);
    qry(32'h40, 1'b1, 32'h90, "retarget");
    chk_cnts("mid");

    // 4: fill, replace through the victim pointer, wrap it
    cyc(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0, "flush");
    qry(32'h40, 1'b0, 32'h44, "flushed");
    for (int i = 0; i < 8; i++) sto(32'h100 + 32'(4 * i), 32'h1100 + 32'(4 * i), 1'b0);
    qry(32'h11C, 1'b1, 32'h111C, "fill_last");
    sto(32'h200, 32'h1200, 1'b0);
    qry(32'h100, 1'b0, 32'h104, "victim0");
    qry(32'h104, 1'b1, 32'h1104, "kept104");
    qry(32'h200, 1'b1, 32'h1200, "new200");
    for (int i = 1; i <= 8; i++) sto(32'h200 + 32'(4 * i), 32'h1200 + 32'(4 * i), 1'b0);
    qry(32'h200, 1'b0, 32'h204, "wrap_gone200");
    qry(32'h11C, 1'b0, 32'h120, "wrap_gone11c");
    qry(32'h220, 1'b1, 32'h1220, "wrap_new220");
    sto(32'h300, 32'h1300, 1'b0);
    qry(32'h204, 1'b0, 32'h208, "ptr1_gone204");
    qry(32'h208, 1'b1, 32'h1208, "ptr1_kept208");

    // 5: flush drops a concurrent store; lookup sees pre-flush contents
    cyc(1'b1, 32'h208, 1'b1, 1'b0, 32'h400, 32'h1400, 1'b1, 1'b1, 32'h1208, "flush_same");
    qry(32'h400, 1'b0, 32'h404, "drop400");
    qry(32'h208, 1'b0, 32'h20C, "flush208");
    qry(32'h220, 1'b0, 32'h224, "flush220");
    chk_cnts("post_flush");

    // 6: statistics from a fresh reset
    do_reset();
    sto(32'h600, 32'h700, 1'b1);
    qry(32'h600, 1'b1, 32'h700, "st_a");
    qry(32'h610, 1'b0, 32'h614, "st_b");
    sto(32'h610, 32'h614, 1'b0);
    qry(32'h600, 1'b1, 32'h700, "st_c");
    sto(32'h600, 32'h700, 1'b1);
    qry(32'h600, 1'b1, 32'h700, "st_d");
    qry(32'h620, 1'b0, 32'h624, "st_e");
    sto(32'h620, 32'h900, 1'b1);
    qry(32'h620, 1'b1, 32'h900, "st_f");
    qry(32'h620, 1'b1, 32'h900, "st_g");
    qry(32'h600, 1'b1, 32'h700, "st_h");
    qry(32'h630, 1'b0, 32'h634, "st_i");
    qry(32'h640, 1'b0, 32'h644, "st_j");
    chk("stat_q_total", query_cnt, 32'd10);
    chk("stat_h_total", hit_cnt, 32'd6);
    chk("stat_c_total", correct_cnt, 32'd3);
    chk_cnts("stat");

    // Asynchronous reset mid-cycle
    #3 clear_n = 1'b0;
    query = 1'b1; pc_query = 32'h600;
    #1;
    chk("async_query_cnt", query_cnt, 32'd0);
    chk("async_hit_cnt", hit_cnt, 32'd0);
    chk("async_correct_cnt", correct_cnt, 32'd0);
    chk("async_success", {31'b0, success}, 32'd0);
    chk("async_predict", predict, 32'h604);
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
